// File: rtl/barrett_precomp.sv
// barrett_precomp: derives the Barrett reduction parameters for a modulus m.
//   k  = bit length of m (leading-one position + 1)
//   mu = floor(2^(2k) / m), computed by a restoring divider that produces
//        one quotient bit per cycle (2k+1 iterations).
// Optional feature macro: BARRETT_PRECOMP_CACHE_EN. It keeps the last good
// (m, mu) pair so that a repeated modulus skips the division.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i, m_i     request and modulus (m_i sampled on the accepted start)
//   busy_o           high whenever the FSM is not idle
//   valid_o          one-cycle pulse when m_o/m_bl_o/mu_o/err_o update
//   err_o            m == 0 or k > DATA_LENGTH/2
//   m_o, m_bl_o, mu_o  captured modulus, bit length, Barrett constant
module barrett_precomp #(
  parameter int unsigned DATA_LENGTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic                   err_o,
  output logic [DATA_LENGTH-1:0] m_o,
  output logic [DATA_LENGTH-1:0] m_bl_o,
  output logic [DATA_LENGTH-1:0] mu_o
);

  localparam int unsigned HALF  = DATA_LENGTH / 2;
  localparam int unsigned REM_W = HALF + 1;
  localparam int unsigned K_W   = $clog2(DATA_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_LENGTH-1:0] m_q, m_d;
  logic [K_W-1:0]         k_q, k_d;
  logic                   err_q, err_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [DATA_LENGTH-1:0] q_q, q_d;
  logic [K_W-1:0]         cnt_q, cnt_d;
  logic                   busy_d, valid_d, err_o_d;
  logic [DATA_LENGTH-1:0] m_o_d, m_bl_d, mu_d;

  logic [K_W-1:0]         k_lod;
  logic                   norm_err;
  logic                   cache_hit;
  logic                   div_bit;
  logic [REM_W-1:0]       rem_sh;

`ifdef BARRETT_PRECOMP_CACHE_EN
  logic                   cache_vld_q, cache_vld_d;
  logic [DATA_LENGTH-1:0] cache_m_q, cache_m_d;
  logic [DATA_LENGTH-1:0] cache_mu_q, cache_mu_d;

  assign cache_hit = cache_vld_q && (m_q == cache_m_q);
`else
  assign cache_hit = 1'b0;
`endif

  // Leading-one detect: k = index of the top set bit + 1, 0 when m == 0.
  always_comb begin
    k_lod = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      if (m_q[i]) k_lod = K_W'(i + 1);
    end
  end

  assign norm_err = (m_q == '0) || (k_lod > K_W'(HALF));

  // The dividend 2^(2k) has a single 1, at bit position 2k (first iteration).
  assign div_bit = (cnt_q == K_W'({k_q, 1'b0}));
  assign rem_sh  = {rem_q[REM_W-2:0], div_bit};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = NORM;
      NORM:    state_d = (norm_err || cache_hit) ? DONE : DIV;
      DIV:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    m_d     = m_q;
    k_d     = k_q;
    err_d   = err_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_o_d = err_o;
    m_o_d   = m_o;
    m_bl_d  = m_bl_o;
    mu_d    = mu_o;
    busy_d  = (state_d != IDLE);
`ifdef BARRETT_PRECOMP_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_m_d   = cache_m_q;
    cache_mu_d  = cache_mu_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) m_d = m_i;
      end
      NORM: begin
        k_d   = k_lod;
        err_d = norm_err;
        rem_d = '0;
        q_d   = '0;
        cnt_d = K_W'({k_lod, 1'b0});
`ifdef BARRETT_PRECOMP_CACHE_EN
        if (cache_hit) q_d = cache_mu_q;
`endif
      end
      DIV: begin
        // rem < m before the shift, so rem_sh < 2m fits in REM_W bits.
        if (rem_sh >= m_q[REM_W-1:0]) begin
          rem_d = rem_sh - m_q[REM_W-1:0];
          q_d   = {q_q[DATA_LENGTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          q_d   = {q_q[DATA_LENGTH-2:0], 1'b0};
        end
        if (cnt_q != '0) cnt_d = cnt_q - K_W'(1);
      end
      DONE: begin
        valid_d = 1'b1;
        err_o_d = err_q;
        m_o_d   = m_q;
        m_bl_d  = DATA_LENGTH'(k_q);
        mu_d    = err_q ? '0 : q_q;
`ifdef BARRETT_PRECOMP_CACHE_EN
        if (err_q) begin
          cache_vld_d = 1'b0;
        end else begin
          cache_vld_d = 1'b1;
          cache_m_d   = m_q;
          cache_mu_d  = q_q;
        end
`endif
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      m_o     <= '0;
      m_bl_o  <= '0;
      mu_o    <= '0;
    end else begin
      m_q     <= m_d;
      k_q     <= k_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_o  <= busy_d;
      valid_o <= valid_d;
      err_o   <= err_o_d;
      m_o     <= m_o_d;
      m_bl_o  <= m_bl_d;
      mu_o    <= mu_d;
    end
  end

`ifdef BARRETT_PRECOMP_CACHE_EN
  // Cache of the last successful result; cleared by reset and by errors.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_vld_q <= 1'b0;
      cache_m_q   <= '0;
      cache_mu_q  <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_m_q   <= cache_m_d;
      cache_mu_q  <= cache_mu_d;
    end
  end
`endif

endmodule

// File: tb/tb_barrett_precomp.sv
// tb_barrett_precomp: table-driven check of barrett_precomp with a scoreboard
// queue of expected results, plus hand-written corner-case sequences.
module tb_barrett_precomp;

  typedef struct {
    logic [63:0] m;
    logic [63:0] bl;
    logic [63:0] mu;
    logic        err;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] m_in;
  logic        busy_o, valid_o, err_o;
  logic [63:0] m_o, m_bl_o, mu_o;

  int total;
  int bad;
  vec_t exp_q[$];
  vec_t vecs[9];

  barrett_precomp #(.DATA_LENGTH(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .m_i    (m_in),
    .busy_o (busy_o),
    .valid_o(valid_o),
    .err_o  (err_o),
    .m_o    (m_o),
    .m_bl_o (m_bl_o),
    .mu_o   (mu_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one start pulse and record the expected result.
  task automatic issue(input logic [63:0] m, input logic [63:0] bl, input logic [63:0] mu,
                       input logic err, input int lat);
    vec_t e;
    e.m = m; e.bl = bl; e.mu = mu; e.err = err; e.lat = lat;
    exp_q.push_back(e);
    m_in  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for valid_o, optionally injecting a second start at cycle inj_cyc.
  task automatic wait_result(input int inj_cyc, input logic [63:0] inj_m, input bit pulse_chk);
    vec_t e;
    int   cyc;
    bit   seen;
    bit   busy_ok;
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inj_cyc > 1) begin
        if (cyc == inj_cyc - 1) begin
          start = 1'b1;
          m_in  = inj_m;
        end else if (cyc == inj_cyc) begin
          start = 1'b0;
        end
      end
      if (valid_o) seen = 1;
      else if (!busy_o) busy_ok = 0;
    end
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue want entry");
      return;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      total++; bad++;
      $display("FAIL timeout m=%0h: got no valid_o want valid_o", e.m);
      return;
    end
    chk($sformatf("latency m=%0h", e.m), 64'(cyc), 64'(e.lat));
    chk($sformatf("m_o m=%0h", e.m), m_o, e.m);
    chk($sformatf("m_bl_o m=%0h", e.m), m_bl_o, e.bl);
    chk($sformatf("mu_o m=%0h", e.m), mu_o, e.mu);
    chk($sformatf("err_o m=%0h", e.m), 64'(err_o), 64'(e.err));
    chk($sformatf("busy_during m=%0h", e.m), 64'(busy_ok), 64'd1);
    if (pulse_chk) begin
      @(posedge clk);
      #1;
      chk($sformatf("valid_pulse m=%0h", e.m), 64'(valid_o), 64'd0);
      chk($sformatf("mu_hold m=%0h", e.m), mu_o, e.mu);
      chk($sformatf("busy_idle m=%0h", e.m), 64'(busy_o), 64'd0);
    end
  endtask

  initial begin
    bit no_valid;
    int hit_lat;
    total = 0;
    bad   = 0;
    start = 1'b0;
    m_in  = '0;
    rst_n = 1'b0;

    vecs[0] = '{64'd5,                    64'd3,  64'd12,                  1'b0, 9};
    vecs[1] = '{64'd1,                    64'd1,  64'd4,                   1'b0, 5};
    vecs[2] = '{64'hFFFF_FFFF,            64'd32, 64'h1_0000_0001,         1'b0, 67};
    vecs[3] = '{64'd0,                    64'd0,  64'd0,                   1'b1, 2};
    vecs[4] = '{64'h1_0000_0000,          64'd33, 64'd0,                   1'b1, 2};
    vecs[5] = '{64'd7,                    64'd3,  64'd9,                   1'b0, 9};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF,  64'd64, 64'd0,                   1'b1, 2};
    vecs[7] = '{64'h8000_0000,            64'd32, 64'h2_0000_0000,         1'b0, 67};
    vecs[8] = '{64'd3,                    64'd2,  64'd5,                   1'b0, 7};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy",  64'(busy_o),  64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_err",   64'(err_o),   64'd0);
    chk("rst_m",     m_o,          64'd0);
    chk("rst_bl",    m_bl_o,       64'd0);
    chk("rst_mu",    mu_o,         64'd0);

    // Main table.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].m, vecs[i].bl, vecs[i].mu, vecs[i].err, vecs[i].lat);
      wait_result(0, '0, 1'b1);
    end

    // Start while busy is ignored.
    issue(64'd5, 64'd3, 64'd12, 1'b0, 9);
    wait_result(4, 64'd7, 1'b1);

    // Asynchronous reset during DIV discards the operation.
    m_in  = 64'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  64'(busy_o),  64'd0);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_err",   64'(err_o),   64'd0);
    chk("midrst_m",     m_o,          64'd0);
    chk("midrst_bl",    m_bl_o,       64'd0);
    chk("midrst_mu",    mu_o,         64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    no_valid = 1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (valid_o || busy_o) no_valid = 0;
    end
    chk("midrst_no_valid", 64'(no_valid), 64'd1);
    issue(64'd7, 64'd3, 64'd9, 1'b0, 9);
    wait_result(0, '0, 1'b1);

    // Back-to-back: next start accepted in the first idle cycle after DONE.
    issue(64'd1, 64'd1, 64'd4, 1'b0, 5);
    wait_result(0, '0, 1'b0);
    issue(64'd5, 64'd3, 64'd12, 1'b0, 9);
    wait_result(0, '0, 1'b1);

    // Repeated modulus; an error result invalidates any cached value.
`ifdef BARRETT_PRECOMP_CACHE_EN
    hit_lat = 2;
`else
    hit_lat = 9;
`endif
    issue(64'd5, 64'd3, 64'd12, 1'b0, hit_lat);
    wait_result(0, '0, 1'b1);
    issue(64'd0, 64'd0, 64'd0, 1'b1, 2);
    wait_result(0, '0, 1'b1);
    issue(64'd5, 64'd3, 64'd12, 1'b0, 9);
    wait_result(0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrett_precomp.md
Name: barrett_precomp

Overview:
- Upstream parameter stage for the bit-parallel Barrett reducer.
- Takes a modulus m and produces the bit length k (m_bl) and the Barrett constant mu = floor(2^(2k) / m).
- Results drive the reducer's m_i, m_bl_i and mu_i inputs.
- Sequential restoring divider that produces one quotient bit per cycle. It trades latency for area because it runs only when the modulus changes.

Parameters:
DATA_LENGTH, 64 (value of multiplier_pkg::DATA_LENGTH), width of the modulus and of every result bus.

Ports:
clk_i  input  1  system clock; all registers are on the rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only in IDLE
m_i  input  DATA_LENGTH  modulus; captured on the accepted start
busy_o  output  1  high in every state except IDLE; the upstream side treats ~busy_o as ready
valid_o  output  1  one-cycle pulse when the outputs update
err_o  output  1  error flag; qualified by valid_o
m_o  output  DATA_LENGTH  captured modulus
m_bl_o  output  DATA_LENGTH  bit length k of m, zero-extended
mu_o  output  DATA_LENGTH  floor(2^(2k)/m), zero-extended

Behaviour:
- Reset values: every output, state register, remainder, quotient and counter is 0; the FSM is in IDLE. Reset is asynchronous and takes effect mid-operation: the operation in flight is discarded and no valid_o is produced.
- FSM states: IDLE, NORM, DIV, DONE.
- IDLE:
  - start_i=1 at edge E0 captures m_i and moves to NORM.
  - start_i=0 stays in IDLE.
- NORM (edge E1):
  - k = index of the most significant 1 in m, plus 1 (leading-one detect).
  - If m==0 or k > DATA_LENGTH/2, set the error flag and go to DONE.
  - Otherwise clear the remainder and quotient, set cnt=2k, and go to DIV.
- DIV (edges E2..E2k+2, i.e. 2k+1 iterations):
  - Dividend bit i is 1 only when i==2k.
  - Each iteration: rem = (rem<<1) | dividend bit cnt. If rem >= m, then rem -= m and q = (q<<1)|1; otherwise q = q<<1.
  - When cnt==0, go to DONE; otherwise cnt is decremented.
  - rem is DATA_LENGTH/2+1 bits. No overflow is possible because rem < 2m.
- DONE (edge E2k+3 on success, E2 on error):
  - Register m_o, m_bl_o, mu_o and err_o.
  - Pulse valid_o for exactly one cycle, then return to IDLE.
  - On error, mu_o=0 and m_bl_o=k (0 when m==0).
- Latency from the accepted start edge to valid_o high:
  - 2k+3 cycles on success.
  - 2 cycles on error.
- Result range: with k <= DATA_LENGTH/2, mu <= 2^(k+1), so mu fits in DATA_LENGTH bits.
- Output hold: outputs hold their last values until the next DONE. valid_o is 0 at all other times.
- Start while busy: start_i while busy_o=1, including in DONE, is ignored. It is not queued.
- Start after DONE: start_i is accepted in the first IDLE cycle following DONE. Back-to-back throughput is therefore one request per 2k+4 cycles.
- Input stability: m_i must be stable only in the start cycle. Later changes have no effect.

Optional Feature:
BARRETT_PRECOMP_CACHE_EN
- Defined:
  - The block keeps the last successfully computed (m, k, mu) plus a cache-valid bit. The cache-valid bit is cleared by reset and by any error result.
  - In NORM, if the cache is valid and captured m equals the cached m, the block skips DIV and goes directly to DONE with the cached values. Latency is 2 cycles and err_o=0.
- Undefined:
  - No cache registers exist, and every request performs the full division.

Test Plan:
- Reset, then m_i=5, start_i for 1 cycle. Required: busy_o high during the operation; valid_o high exactly 9 cycles after start; m_bl_o=3, mu_o=12, err_o=0, m_o=5.
- m_i=1. Required: latency 5, m_bl_o=1, mu_o=4.
- m_i=32'hFFFF_FFFF (DATA_LENGTH=64). Required: latency 67, m_bl_o=32, mu_o=64'h1_0000_0001.
- m_i=0 and m_i=64'h1_0000_0000. Required: each gives latency 2 with err_o=1 and mu_o=0; m_bl_o=0 and 33 respectively.
- Start m=5, then pulse start_i with m_i=7 at cycle 4. Required: the second request is ignored and the result is still mu_o=12. Separately, drive rst_ni low during DIV. Required: outputs return to 0 immediately, no valid_o pulse appears, and a subsequent m=7 start yields mu_o=9 at latency 9.
- With BARRETT_PRECOMP_CACHE_EN: m=5, then m=5 again. Required: the second result has latency 2 and mu_o=12. Then m=0, then m=5. Required: the error clears the cache, so the m=5 result takes the full latency of 9.
